// File: rtl/pkt_len_meter.sv
// Per-packet byte meter: emits size/flow one cycle after each eop word; framing errors dropped and counted.
// Latency 1 cycle from the accepting edge; no backpressure, every valid word is accepted.
module pkt_len_meter #(
    parameter int A_WIDTH = 10,
    parameter int BYTES   = 8,
    localparam int EW     = $clog2(BYTES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pkt_valid_i,
    input  logic               pkt_sop_i,
    input  logic               pkt_eop_i,
    input  logic [EW-1:0]      pkt_empty_i,
    input  logic [A_WIDTH-1:0] pkt_flow_num_i,
    output logic [A_WIDTH-1:0] rx_flow_num_o,
    output logic [15:0]        pkt_size_o,
    output logic               pkt_size_en_o,
    output logic               err_o,
    output logic [15:0]        err_cnt_o
);

    localparam logic [0:0]  IDLE    = 1'b0;
    localparam logic [0:0]  IN_PKT  = 1'b1;
    localparam logic [15:0] BYTES16 = 16'(BYTES);
    localparam logic [16:0] BYTES17 = 17'(BYTES);

    logic [0:0]         state, state_nxt;
    logic [16:0]        acc, acc_nxt;
    logic               sat, sat_nxt;
    logic [A_WIDTH-1:0] flow_cap, flow_nxt;
    logic [A_WIDTH-1:0] rx_flow_nxt;
    logic [15:0]        size_nxt;
    logic               size_en_nxt;
    logic               err_nxt;
    logic [15:0]        word_bytes;
    logic [16:0]        sum;
    logic               sum_ovf;

    assign word_bytes = pkt_eop_i ? (BYTES16 - 16'(pkt_empty_i)) : BYTES16;
    assign sum        = acc + {1'b0, word_bytes};
    // acc is clamped at 17'h10000, so bit 16 alone flags overflow.
    assign sum_ovf    = sum[16];

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        sat_nxt     = sat;
        flow_nxt    = flow_cap;
        rx_flow_nxt = rx_flow_num_o;
        size_nxt    = pkt_size_o;
        size_en_nxt = 1'b0;
        err_nxt     = 1'b0;
        if (pkt_valid_i) begin
            if (pkt_sop_i) begin
                // A sop inside an open packet aborts it, then starts afresh.
                err_nxt = (state == IN_PKT);
                if (pkt_eop_i) begin
                    size_en_nxt = 1'b1;
                    size_nxt    = word_bytes;
                    rx_flow_nxt = pkt_flow_num_i;
                    state_nxt   = IDLE;
                end else begin
                    acc_nxt   = BYTES17;
                    sat_nxt   = 1'b0;
                    flow_nxt  = pkt_flow_num_i;
                    state_nxt = IN_PKT;
                end
            end else if (state == IDLE) begin
                err_nxt = 1'b1;
            end else if (pkt_eop_i) begin
                size_en_nxt = 1'b1;
                size_nxt    = (sat || sum_ovf) ? 16'hFFFF : sum[15:0];
                rx_flow_nxt = flow_cap;
                state_nxt   = IDLE;
            end else begin
                acc_nxt = sum_ovf ? 17'h10000 : sum;
                sat_nxt = sat | sum_ovf;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            acc           <= '0;
            sat           <= 1'b0;
            flow_cap      <= '0;
            rx_flow_num_o <= '0;
            pkt_size_o    <= '0;
            pkt_size_en_o <= 1'b0;
            err_o         <= 1'b0;
            err_cnt_o     <= '0;
        end else begin
            state         <= state_nxt;
            acc           <= acc_nxt;
            sat           <= sat_nxt;
            flow_cap      <= flow_nxt;
            rx_flow_num_o <= rx_flow_nxt;
            pkt_size_o    <= size_nxt;
            pkt_size_en_o <= size_en_nxt;
            err_o         <= err_nxt;
            if (err_nxt && (err_cnt_o != 16'hFFFF)) begin
                err_cnt_o <= err_cnt_o + 16'd1;
            end
        end
    end

endmodule
